autoscale_frame_ctrl: RTL and testbench

- Block-floating-point shift scheduler for the autoscale datapath.
- Per-sample, it takes the MSB index of the (din1 | din2) word produced by the first-one finder stage, and tracks the worst-case magnitude over each frame.
- At the end of each frame it computes one clamped shift and applies it with asymmetric hysteresis: it drops the shift immediately and raises it only after several frames agree.
- It drives the shift input of the shifter stage, so that a whole spectrum or integration frame shares one scale.

---
 rtl/autoscale_frame_ctrl_if.sv | 31 +++
 rtl/autoscale_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_autoscale_frame_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/autoscale_frame_ctrl_if.sv
// Sample-statistics and shift-control bus of the autoscale frame controller.
// The master drives the per-sample MSB stream and override; the slave returns the scale.
interface autoscale_frame_ctrl_if #(
    parameter int DIN_WIDTH   = 32,
    parameter int HOLD_FRAMES = 4
);
    localparam int SW = $clog2(DIN_WIDTH);
    localparam int UW = $clog2(HOLD_FRAMES + 1);

    logic          sync_in;
    logic          msb_valid;
    logic [SW-1:0] msb_idx;
    logic          msb_nz;
    logic          force_en;
    logic [SW-1:0] force_shift;
    logic [SW-1:0] shift_cfg;
    logic          shift_update;
    logic          frame_done;
    logic          clip_flag;
    logic [UW-1:0] up_cnt;

    modport master (
        output sync_in, msb_valid, msb_idx, msb_nz, force_en, force_shift,
        input  shift_cfg, shift_update, frame_done, clip_flag, up_cnt
    );

    modport slave (
        input  sync_in, msb_valid, msb_idx, msb_nz, force_en, force_shift,
        output shift_cfg, shift_update, frame_done, clip_flag, up_cnt
    );
endinterface

// File: rtl/autoscale_frame_ctrl.sv
// Block-floating-point shift scheduler: tracks each frame's peak MSB index and
// derives one clamped shift per frame, lowered at once and raised only after agreement.
module autoscale_frame_ctrl #(
    parameter int DIN_WIDTH   = 32,
    parameter int MAX_SHIFT   = 10,
    parameter int MIN_SHIFT   = 3,
    parameter int HEADROOM    = 2,
    parameter int FRAME_LEN   = 1024,
    parameter int HOLD_FRAMES = 4,
    parameter int INIT_SHIFT  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    autoscale_frame_ctrl_if.slave bus
);
    localparam int SW = $clog2(DIN_WIDTH);
    localparam int UW = $clog2(HOLD_FRAMES + 1);
    localparam int CW = $clog2(FRAME_LEN);

    localparam logic [CW-1:0]        LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [UW-1:0]        HOLD_U   = UW'(HOLD_FRAMES);
    localparam logic [SW-1:0]        MIN_U    = SW'(MIN_SHIFT);
    localparam logic [SW-1:0]        MAX_U    = SW'(MAX_SHIFT);
    localparam logic signed [SW+1:0] MIN_S    = (SW+2)'(MIN_SHIFT);
    localparam logic signed [SW+1:0] MAX_S    = (SW+2)'(MAX_SHIFT);
    localparam logic signed [SW+1:0] RAW_BASE = (SW+2)'(DIN_WIDTH - 1 - HEADROOM);

    typedef enum logic {
        WAIT_SYNC,
        ACCUM
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   sampleCnt_q;
    logic [SW-1:0]   runMax_q;
    logic            runNz_q;
    logic [SW-1:0]   snapMax_q;
    logic            snapNz_q;
    logic            snapValid_q;
    logic [SW-1:0]   target_q;
    logic            tgtValid_q;
    logic [SW-1:0]   shiftCfg_q;
    logic            shiftUpdate_q;
    logic            frameDone_q;
    logic            clipFlag_q;
    logic [UW-1:0]   upCnt_q;

    logic            sampleNz;
    logic [SW-1:0]   mergedMax;
    logic            mergedNz;
    logic [CW-1:0]   startCnt;
    logic [SW-1:0]   startMax;
    logic            lastSample;
    logic signed [SW+1:0] rawShift;
    logic [SW-1:0]   target_d;
    logic [SW-1:0]   forceShift_d;
    logic [UW-1:0]   upInc_d;

    always_comb begin
        sampleNz   = bus.msb_valid & bus.msb_nz;
        mergedMax  = runMax_q;
        if (sampleNz && (bus.msb_idx > runMax_q)) begin
            mergedMax = bus.msb_idx;
        end
        mergedNz   = runNz_q | sampleNz;
        startCnt   = bus.msb_valid ? CW'(1) : '0;
        startMax   = sampleNz ? bus.msb_idx : '0;
        lastSample = (state_q == ACCUM) && bus.msb_valid && (sampleCnt_q == LAST_IDX);

        // A frame with no nonzero sample carries no magnitude, so it asks for the largest shift.
        rawShift = MAX_S;
        if (snapNz_q) begin
            rawShift = RAW_BASE - $signed({2'b00, snapMax_q});
        end
        if (rawShift < MIN_S) begin
            target_d = MIN_U;
        end else if (rawShift > MAX_S) begin
            target_d = MAX_U;
        end else begin
            target_d = rawShift[SW-1:0];
        end

        if (bus.force_shift < MIN_U) begin
            forceShift_d = MIN_U;
        end else if (bus.force_shift > MAX_U) begin
            forceShift_d = MAX_U;
        end else begin
            forceShift_d = bus.force_shift;
        end

        upInc_d = upCnt_q + UW'(1);
    end

    // Frame accumulation, two-stage evaluation pipeline and hysteresis share one register block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= WAIT_SYNC;
            sampleCnt_q   <= '0;
            runMax_q      <= '0;
            runNz_q       <= 1'b0;
            snapMax_q     <= '0;
            snapNz_q      <= 1'b0;
            snapValid_q   <= 1'b0;
            target_q      <= '0;
            tgtValid_q    <= 1'b0;
            shiftCfg_q    <= SW'(INIT_SHIFT);
            shiftUpdate_q <= 1'b0;
            frameDone_q   <= 1'b0;
            clipFlag_q    <= 1'b0;
            upCnt_q       <= '0;
        end else begin
            snapValid_q   <= 1'b0;
            tgtValid_q    <= 1'b0;
            frameDone_q   <= 1'b0;
            shiftUpdate_q <= 1'b0;

            case (state_q)
                WAIT_SYNC: begin
                    if (bus.sync_in) begin
                        state_q     <= ACCUM;
                        sampleCnt_q <= startCnt;
                        runMax_q    <= startMax;
                        runNz_q     <= sampleNz;
                    end
                end
                ACCUM: begin
                    // The frame-end sample closes its own frame even if sync arrives with it.
                    if (lastSample) begin
                        snapMax_q   <= mergedMax;
                        snapNz_q    <= mergedNz;
                        snapValid_q <= 1'b1;
                        sampleCnt_q <= '0;
                        runMax_q    <= '0;
                        runNz_q     <= 1'b0;
                    end else if (bus.sync_in) begin
                        sampleCnt_q <= startCnt;
                        runMax_q    <= startMax;
                        runNz_q     <= sampleNz;
                    end else if (bus.msb_valid) begin
                        sampleCnt_q <= sampleCnt_q + CW'(1);
                        runMax_q    <= mergedMax;
                        runNz_q     <= mergedNz;
                    end
                end
                default: state_q <= WAIT_SYNC;
            endcase

            if (snapValid_q) begin
                target_q   <= target_d;
                clipFlag_q <= (rawShift < MIN_S);
                tgtValid_q <= 1'b1;
            end

            if (tgtValid_q) begin
                frameDone_q <= 1'b1;
            end

            if (bus.force_en) begin
                shiftCfg_q    <= forceShift_d;
                upCnt_q       <= '0;
                shiftUpdate_q <= (forceShift_d != shiftCfg_q);
            end else if (tgtValid_q) begin
                if (target_q < shiftCfg_q) begin
                    shiftCfg_q    <= target_q;
                    upCnt_q       <= '0;
                    shiftUpdate_q <= 1'b1;
                end else if (target_q == shiftCfg_q) begin
                    upCnt_q <= '0;
                end else if (upInc_d == HOLD_U) begin
                    shiftCfg_q    <= target_q;
                    upCnt_q       <= '0;
                    shiftUpdate_q <= 1'b1;
                end else begin
                    upCnt_q <= upInc_d;
                end
            end
        end
    end

    assign bus.shift_cfg    = shiftCfg_q;
    assign bus.shift_update = shiftUpdate_q;
    assign bus.frame_done   = frameDone_q;
    assign bus.clip_flag    = clipFlag_q;
    assign bus.up_cnt       = upCnt_q;
endmodule

// File: tb/tb_autoscale_frame_ctrl.sv
// Directed bench for autoscale_frame_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_autoscale_frame_ctrl;
    localparam int SW = 5;
    localparam int FL = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    autoscale_frame_ctrl_if #(.DIN_WIDTH(32), .HOLD_FRAMES(4)) bus ();

    autoscale_frame_ctrl #(
        .DIN_WIDTH(32), .MAX_SHIFT(10), .MIN_SHIFT(3), .HEADROOM(2),
        .FRAME_LEN(FL), .HOLD_FRAMES(4), .INIT_SHIFT(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // One clock with the given sample; outputs are observed 1 time unit after the edge.
    task automatic cyc(input logic s, input logic v, input logic [SW-1:0] idx, input logic nz);
        bus.sync_in   = s;
        bus.msb_valid = v;
        bus.msb_idx   = idx;
        bus.msb_nz    = nz;
        @(posedge clk);
        #1;
        bus.sync_in   = 1'b0;
        bus.msb_valid = 1'b0;
        bus.msb_idx   = '0;
        bus.msb_nz    = 1'b0;
    endtask

    task automatic runFrame(input logic withSync, input logic [SW-1:0] fillIdx, input logic fillNz,
                            input int spPos, input logic [SW-1:0] spIdx);
        for (int i = 0; i < FL; i++) begin
            if (i == spPos) cyc(withSync && (i == 0), 1'b1, spIdx, 1'b1);
            else            cyc(withSync && (i == 0), 1'b1, fillIdx, fillNz);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_cfg !== 5'd3) begin miscompares++; $display("[TB] FAIL reset_shift: got %0d expected 3", bus.shift_cfg); end
        vectors++; if (bus.shift_update !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_update: got %0b expected 0", bus.shift_update); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.frame_done); end
        vectors++; if (bus.clip_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clip: got %0b expected 0", bus.clip_flag); end
        vectors++; if (bus.up_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_upcnt: got %0d expected 0", bus.up_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_hold_increase();
        int expShift, expUp;
        logic expUpd;
        for (int f = 1; f <= 4; f++) begin
            runFrame(f == 1, 5'd20, 1'b1, -1, 5'd0);
            cyc(0, 0, 0, 0);
            vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_e1_done f%0d: got %0b expected 0", f, bus.frame_done); end
            vectors++; if (bus.shift_cfg !== 5'd3) begin miscompares++; $display("[TB] FAIL hold_e1_shift f%0d: got %0d expected 3", f, bus.shift_cfg); end
            cyc(0, 0, 0, 0);
            expShift = (f == 4) ? 9 : 3;
            expUp    = (f == 4) ? 0 : f;
            expUpd   = (f == 4);
            vectors++; if (bus.frame_done !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_done f%0d: got %0b expected 1", f, bus.frame_done); end
            vectors++; if (bus.shift_cfg !== expShift[SW-1:0]) begin miscompares++; $display("[TB] FAIL hold_shift f%0d: got %0d expected %0d", f, bus.shift_cfg, expShift); end
            vectors++; if (bus.up_cnt !== expUp[2:0]) begin miscompares++; $display("[TB] FAIL hold_upcnt f%0d: got %0d expected %0d", f, bus.up_cnt, expUp); end
            vectors++; if (bus.shift_update !== expUpd) begin miscompares++; $display("[TB] FAIL hold_update f%0d: got %0b expected %0b", f, bus.shift_update, expUpd); end
            vectors++; if (bus.clip_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_clip f%0d: got %0b expected 0", f, bus.clip_flag); end
        end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_update !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_update_pulse: got %0b expected 0", bus.shift_update); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_done_pulse: got %0b expected 0", bus.frame_done); end
    endtask

    task automatic test_drop_immediate();
        runFrame(0, 5'd0, 1'b0, 300, 5'd26);
        cyc(0, 0, 0, 0);
        vectors++; if (bus.clip_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_clip: got %0b expected 0", bus.clip_flag); end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_cfg !== 5'd3) begin miscompares++; $display("[TB] FAIL drop_shift: got %0d expected 3", bus.shift_cfg); end
        vectors++; if (bus.shift_update !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_update: got %0b expected 1", bus.shift_update); end
        vectors++; if (bus.up_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL drop_upcnt: got %0d expected 0", bus.up_cnt); end
    endtask

    task automatic test_clip();
        runFrame(0, 5'd0, 1'b0, 700, 5'd28);
        cyc(0, 0, 0, 0);
        vectors++; if (bus.clip_flag !== 1'b1) begin miscompares++; $display("[TB] FAIL clip_flag_set: got %0b expected 1", bus.clip_flag); end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_cfg !== 5'd3) begin miscompares++; $display("[TB] FAIL clip_shift: got %0d expected 3", bus.shift_cfg); end
        vectors++; if (bus.shift_update !== 1'b0) begin miscompares++; $display("[TB] FAIL clip_update: got %0b expected 0", bus.shift_update); end
        vectors++; if (bus.clip_flag !== 1'b1) begin miscompares++; $display("[TB] FAIL clip_flag_hold: got %0b expected 1", bus.clip_flag); end
        runFrame(0, 5'd10, 1'b1, -1, 5'd0);
        cyc(0, 0, 0, 0);
        vectors++; if (bus.clip_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL clip_flag_clear: got %0b expected 0", bus.clip_flag); end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_cfg !== 5'd3) begin miscompares++; $display("[TB] FAIL max10_shift: got %0d expected 3", bus.shift_cfg); end
        vectors++; if (bus.up_cnt !== 3'd1) begin miscompares++; $display("[TB] FAIL max10_upcnt: got %0d expected 1", bus.up_cnt); end
    endtask

    task automatic test_all_zero_interleave();
        int kind[6]     = '{0, 1, 0, 0, 0, 0};
        int expUp[6]    = '{2, 0, 1, 2, 3, 0};
        int expShift[6] = '{3, 3, 3, 3, 3, 10};
        for (int f = 0; f < 6; f++) begin
            if (kind[f] == 1) runFrame(0, 5'd0, 1'b0, 10, 5'd26);
            else              runFrame(0, 5'd17, 1'b0, -1, 5'd0);
            cyc(0, 0, 0, 0);
            cyc(0, 0, 0, 0);
            vectors++; if (bus.up_cnt !== expUp[f][2:0]) begin miscompares++; $display("[TB] FAIL zero_upcnt f%0d: got %0d expected %0d", f, bus.up_cnt, expUp[f]); end
            vectors++; if (bus.shift_cfg !== expShift[f][SW-1:0]) begin miscompares++; $display("[TB] FAIL zero_shift f%0d: got %0d expected %0d", f, bus.shift_cfg, expShift[f]); end
            vectors++; if (bus.shift_update !== (f == 5)) begin miscompares++; $display("[TB] FAIL zero_update f%0d: got %0b expected %0b", f, bus.shift_update, (f == 5)); end
        end
    endtask

    task automatic test_abort();
        int spurious = 0;
        for (int i = 0; i < 500; i++) begin
            cyc(0, 1, 5'd25, 1);
            if (bus.frame_done === 1'b1) spurious++;
        end
        cyc(1, 1, 5'd5, 1);
        for (int i = 0; i < FL - 1; i++) begin
            cyc(0, 1, 5'd5, 1);
            if (bus.frame_done === 1'b1) spurious++;
        end
        vectors++; if (spurious !== 0) begin miscompares++; $display("[TB] FAIL abort_spurious_done: got %0d expected 0", spurious); end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_e1_done: got %0b expected 0", bus.frame_done); end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.frame_done !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_done: got %0b expected 1", bus.frame_done); end
        vectors++; if (bus.shift_cfg !== 5'd10) begin miscompares++; $display("[TB] FAIL abort_shift: got %0d expected 10", bus.shift_cfg); end
        vectors++; if (bus.shift_update !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_update: got %0b expected 0", bus.shift_update); end
    endtask

    task automatic test_back_to_back();
        int fdCnt = 0;
        int fdPos[4] = '{0, 0, 0, 0};
        int expPos[3] = '{1025, 2049, 3073};
        logic [SW-1:0] idx;
        for (int g = 0; g < 3074; g++) begin
            if (g < 1024)      idx = 5'd22;
            else if (g < 2048) idx = 5'd24;
            else               idx = 5'd20;
            if (g < 3072) cyc(g == 2047, 1, idx, 1);
            else          cyc(0, 0, 0, 0);
            if (bus.frame_done === 1'b1) begin
                if (fdCnt < 4) fdPos[fdCnt] = g;
                fdCnt++;
            end
        end
        vectors++; if (fdCnt !== 3) begin miscompares++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", fdCnt); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (fdPos[k] !== expPos[k]) begin miscompares++; $display("[TB] FAIL b2b_done_pos%0d: got %0d expected %0d", k, fdPos[k], expPos[k]); end
        end
        vectors++; if (bus.shift_cfg !== 5'd5) begin miscompares++; $display("[TB] FAIL b2b_shift: got %0d expected 5", bus.shift_cfg); end
        vectors++; if (bus.up_cnt !== 3'd1) begin miscompares++; $display("[TB] FAIL b2b_upcnt: got %0d expected 1", bus.up_cnt); end
    endtask

    task automatic test_reset_mid_eval();
        int spurious = 0;
        runFrame(0, 5'd25, 1'b1, -1, 5'd0);
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        vectors++; if (bus.shift_cfg !== 5'd3) begin miscompares++; $display("[TB] FAIL rst_eval_shift: got %0d expected 3", bus.shift_cfg); end
        vectors++; if (bus.up_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_eval_upcnt: got %0d expected 0", bus.up_cnt); end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_eval_done: got %0b expected 0", bus.frame_done); end
        vectors++; if (bus.shift_cfg !== 5'd3) begin miscompares++; $display("[TB] FAIL rst_eval_shift2: got %0d expected 3", bus.shift_cfg); end
        for (int i = 0; i < FL + 3; i++) begin
            if (i < FL) cyc(0, 1, 5'd10, 1);
            else        cyc(0, 0, 0, 0);
            if (bus.frame_done === 1'b1) spurious++;
        end
        vectors++; if (spurious !== 0) begin miscompares++; $display("[TB] FAIL rst_wait_sync_done: got %0d expected 0", spurious); end
        vectors++; if (bus.up_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_wait_sync_upcnt: got %0d expected 0", bus.up_cnt); end
    endtask

    task automatic test_force();
        bus.force_shift = 5'd15;
        bus.force_en    = 1'b1;
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_cfg !== 5'd10) begin miscompares++; $display("[TB] FAIL force_hi_shift: got %0d expected 10", bus.shift_cfg); end
        vectors++; if (bus.shift_update !== 1'b1) begin miscompares++; $display("[TB] FAIL force_hi_update: got %0b expected 1", bus.shift_update); end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_update !== 1'b0) begin miscompares++; $display("[TB] FAIL force_steady_update: got %0b expected 0", bus.shift_update); end
        bus.force_shift = 5'd1;
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_cfg !== 5'd3) begin miscompares++; $display("[TB] FAIL force_lo_shift: got %0d expected 3", bus.shift_cfg); end
        bus.force_shift = 5'd7;
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_cfg !== 5'd7) begin miscompares++; $display("[TB] FAIL force_mid_shift: got %0d expected 7", bus.shift_cfg); end
        vectors++; if (bus.shift_update !== 1'b1) begin miscompares++; $display("[TB] FAIL force_mid_update: got %0b expected 1", bus.shift_update); end
        runFrame(1, 5'd28, 1'b1, -1, 5'd0);
        cyc(0, 0, 0, 0);
        vectors++; if (bus.clip_flag !== 1'b1) begin miscompares++; $display("[TB] FAIL force_clip: got %0b expected 1", bus.clip_flag); end
        cyc(0, 0, 0, 0);
        vectors++; if (bus.frame_done !== 1'b1) begin miscompares++; $display("[TB] FAIL force_done: got %0b expected 1", bus.frame_done); end
        vectors++; if (bus.shift_cfg !== 5'd7) begin miscompares++; $display("[TB] FAIL force_frame_shift: got %0d expected 7", bus.shift_cfg); end
        vectors++; if (bus.up_cnt !== 3'd0) begin miscompares++; $display("[TB] FAIL force_upcnt: got %0d expected 0", bus.up_cnt); end
        bus.force_en = 1'b0;
        runFrame(0, 5'd25, 1'b1, -1, 5'd0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        vectors++; if (bus.shift_cfg !== 5'd4) begin miscompares++; $display("[TB] FAIL resume_shift: got %0d expected 4", bus.shift_cfg); end
        vectors++; if (bus.shift_update !== 1'b1) begin miscompares++; $display("[TB] FAIL resume_update: got %0b expected 1", bus.shift_update); end
    endtask

    initial begin
        bus.sync_in     = 1'b0;
        bus.msb_valid   = 1'b0;
        bus.msb_idx     = '0;
        bus.msb_nz      = 1'b0;
        bus.force_en    = 1'b0;
        bus.force_shift = '0;
        $display("[TB] start");
        test_reset();
        test_hold_increase();
        test_drop_immediate();
        test_clip();
        test_all_zero_interleave();
        test_abort();
        test_back_to_back();
        test_reset_mid_eval();
        test_force();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
